// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU-side definitions: IO/HRAM address map, interrupt bit positions and TAC clock selection.
package gb_cpu_common_pkg;

    localparam logic [15:0] ADDR_DIV       = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA      = 16'hFF05;
    localparam logic [15:0] ADDR_TMA       = 16'hFF06;
    localparam logic [15:0] ADDR_TAC       = 16'hFF07;
    localparam logic [15:0] ADDR_IF        = 16'hFF0F;
    localparam logic [15:0] ADDR_HRAM_BASE = 16'hFF80;
    localparam logic [15:0] ADDR_HRAM_END  = 16'hFFFE;

    typedef enum logic [2:0] {
        IRQ_VBLANK = 3'd0,
        IRQ_STAT   = 3'd1,
        IRQ_TIMER  = 3'd2,
        IRQ_SERIAL = 3'd3,
        IRQ_JOYPAD = 3'd4
    } irq_bit_t;

    typedef enum logic [1:0] {
        TAC_CLK_4096   = 2'b00,
        TAC_CLK_262144 = 2'b01,
        TAC_CLK_65536  = 2'b10,
        TAC_CLK_16384  = 2'b11
    } tac_clk_sel_t;

    // Bit of the 16-bit system counter whose falling edge clocks TIMA.
    function automatic logic [3:0] tac_sys_bit(input tac_clk_sel_t sel);
        logic [3:0] idx;
        case (sel)
            TAC_CLK_262144: idx = 4'd3;
            TAC_CLK_65536:  idx = 4'd5;
            TAC_CLK_16384:  idx = 4'd7;
            default:        idx = 4'd9;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/gb_timer.sv
// DMG-style timer: system counter (DIV), TIMA/TMA/TAC, falling-edge tick detect and overflow reload.
// Optional macro GB_TIMA_RELOAD_DELAY_EN adds the one-cycle TIMA=0x00 window before reload.
module gb_timer
    import gb_cpu_common_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_div_i,
    input  logic       wr_tima_i,
    input  logic       wr_tma_i,
    input  logic       wr_tac_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] div_o,
    output logic [7:0] tima_o,
    output logic [7:0] tma_o,
    output logic [2:0] tac_o,
    output logic       timer_irq_o
);

    logic [15:0] sys_q, sys_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        t_prev_q, t_prev_d;
    logic        t_now;
    logic        tick;
    logic [7:0]  reload_val;
`ifdef GB_TIMA_RELOAD_DELAY_EN
    logic        pend_q, pend_d;
    logic        reloaded_q, reloaded_d;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        sys_d       = wr_div_i ? 16'h0000 : sys_q + 16'd4;
        tma_d       = wr_tma_i ? wdata_i : tma_q;
        tac_d       = wr_tac_i ? wdata_i[2:0] : tac_q;
        t_now       = tac_q[2] & sys_q[tac_sys_bit(tac_clk_sel_t'(tac_q[1:0]))];
        t_prev_d    = t_now;
        tick        = t_prev_q & ~t_now;
        reload_val  = tma_d;
        tima_d      = tima_q;
        timer_irq_o = 1'b0;
`ifdef GB_TIMA_RELOAD_DELAY_EN
        pend_d      = 1'b0;
        reloaded_d  = 1'b0;
        // Pending cycle shows 0x00; a CPU write here cancels both reload and interrupt.
        if (pend_q) begin
            if (wr_tima_i) begin
                tima_d = wdata_i;
            end else begin
                tima_d      = reload_val;
                timer_irq_o = 1'b1;
                reloaded_d  = 1'b1;
            end
        end else if (wr_tima_i && !reloaded_q) begin
            tima_d = wdata_i;
        end else if (tick) begin
            if (tima_q == 8'hFF) begin
                tima_d = 8'h00;
                pend_d = 1'b1;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end
`else
        if (wr_tima_i) begin
            tima_d = wdata_i;
        end else if (tick) begin
            if (tima_q == 8'hFF) begin
                tima_d      = reload_val;
                timer_irq_o = 1'b1;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_q      <= 16'h0000;
            tima_q     <= 8'h00;
            tma_q      <= 8'h00;
            tac_q      <= 3'b000;
            t_prev_q   <= 1'b0;
`ifdef GB_TIMA_RELOAD_DELAY_EN
            pend_q     <= 1'b0;
            reloaded_q <= 1'b0;
`endif
        end else begin
            sys_q      <= sys_d;
            tima_q     <= tima_d;
            tma_q      <= tma_d;
            tac_q      <= tac_d;
            t_prev_q   <= t_prev_d;
`ifdef GB_TIMA_RELOAD_DELAY_EN
            pend_q     <= pend_d;
            reloaded_q <= reloaded_d;
`endif
        end
    end

    assign div_o  = sys_q[15:8];
    assign tima_o = tima_q;
    assign tma_o  = tma_q;
    assign tac_o  = tac_q;

endmodule

// File: rtl/gb_io_hram_responder.sv
// Bus responder for HRAM, IF and the timer registers; registered read data, IF interrupt flags.
// Build option GB_TIMA_RELOAD_DELAY_EN selects the delayed TIMA reload inside gb_timer.
module gb_io_hram_responder
    import gb_cpu_common_pkg::*;
#(
    parameter int HRAM_DEPTH = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    input  logic        wr_i,
    input  logic        rd_i,
    output logic        sel_o,
    output logic [7:0]  rdata_o,
    output logic        rvalid_o,
    input  logic [4:0]  irq_req_i,
    input  logic [4:0]  irq_ack_i,
    output logic [4:0]  if_o
);

    localparam logic [7:0] HRAM_LIMIT = 8'(HRAM_DEPTH);

    logic       sel_tmr, sel_if, sel_hram;
    logic [6:0] hram_idx;
    logic       wr_en;
    logic [7:0] hram_q [HRAM_DEPTH];
    logic [4:0] if_q, if_d, if_set;
    logic [7:0] rdata_q, rdata_d, rd_val;
    logic       rvalid_q, rvalid_d;
    logic [7:0] div, tima, tma;
    logic [2:0] tac;
    logic       timer_irq;

    assign hram_idx = addr_i[6:0];
    assign sel_tmr  = (addr_i[15:2] == ADDR_DIV[15:2]);
    assign sel_if   = (addr_i == ADDR_IF);
    assign sel_hram = (addr_i[15:7] == ADDR_HRAM_BASE[15:7]) && ({1'b0, hram_idx} < HRAM_LIMIT);
    assign sel_o    = sel_tmr | sel_if | sel_hram;
    assign wr_en    = wr_i & sel_o;

    gb_timer u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_div_i    (wr_en && sel_tmr && (addr_i[1:0] == ADDR_DIV[1:0])),
        .wr_tima_i   (wr_en && sel_tmr && (addr_i[1:0] == ADDR_TIMA[1:0])),
        .wr_tma_i    (wr_en && sel_tmr && (addr_i[1:0] == ADDR_TMA[1:0])),
        .wr_tac_i    (wr_en && sel_tmr && (addr_i[1:0] == ADDR_TAC[1:0])),
        .wdata_i     (wdata_i),
        .div_o       (div),
        .tima_o      (tima),
        .tma_o       (tma),
        .tac_o       (tac),
        .timer_irq_o (timer_irq)
    );

    // NOTE: HRAM contents survive reset, so the array lives in a clock-only process with no reset term.
    always_ff @(posedge clk) begin
        if (wr_en && sel_hram) begin
            hram_q[hram_idx] <= wdata_i;
        end
    end

    // Read value is taken before this cycle's write lands, so rd&wr returns the old contents.
    always_comb begin
        rd_val = 8'h00;
        if (sel_hram) begin
            rd_val = hram_q[hram_idx];
        end else if (sel_if) begin
            rd_val = {3'b111, if_q};
        end else begin
            case (addr_i[1:0])
                2'd0:    rd_val = div;
                2'd1:    rd_val = tima;
                2'd2:    rd_val = tma;
                default: rd_val = {5'b11111, tac};
            endcase
        end
        rvalid_d = rd_i & sel_o;
        rdata_d  = rvalid_d ? rd_val : rdata_q;
    end

    // Per-bit priority: request/timer set beats CPU write, which beats dispatch ack.
    always_comb begin
        if_set            = irq_req_i;
        if_set[IRQ_TIMER] = timer_irq;
        if_d              = if_q;
        for (int i = 0; i < 5; i++) begin
            if (if_set[i]) begin
                if_d[i] = 1'b1;
            end else if (wr_en && sel_if) begin
                if_d[i] = wdata_i[i];
            end else if (irq_ack_i[i]) begin
                if_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_q     <= 5'h00;
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
        end else begin
            if_q     <= if_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign if_o     = if_q;

endmodule

// File: tb/tb_gb_io_hram_responder.sv
// Self-checking bench: behavioural register-map model compared every cycle, plus directed literal checks.
module tb_gb_io_hram_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr_i;
    logic [7:0]  wdata_i;
    logic        wr_i;
    logic        rd_i;
    logic        sel_o;
    logic [7:0]  rdata_o;
    logic        rvalid_o;
    logic [4:0]  irq_req_i;
    logic [4:0]  irq_ack_i;
    logic [4:0]  if_o;

    int total = 0;
    int bad   = 0;

    gb_io_hram_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .wr_i      (wr_i),
        .rd_i      (rd_i),
        .sel_o     (sel_o),
        .rdata_o   (rdata_o),
        .rvalid_o  (rvalid_o),
        .irq_req_i (irq_req_i),
        .irq_ack_i (irq_ack_i),
        .if_o      (if_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] m_sys;
    logic [7:0]  m_tima, m_tma;
    logic [2:0]  m_tac;
    logic        m_tprev;
    logic [4:0]  m_if;
    logic [7:0]  m_rdata;
    logic        m_rvalid;
    logic        m_rknown;
    logic [7:0]  m_hram [128];
    logic        m_ok   [128];
    logic [3:0]  kmap   [4] = '{4'd9, 4'd3, 4'd5, 4'd7};
`ifdef GB_TIMA_RELOAD_DELAY_EN
    int          m_stage;   // 0 normal, 1 showing 0x00 after overflow, 2 just reloaded
`endif

    initial for (int i = 0; i < 128; i++) m_ok[i] = 1'b0;

    function automatic logic in_range(input logic [15:0] a);
        return (a >= 16'hFF04 && a <= 16'hFF07) || a == 16'hFF0F || (a >= 16'hFF80 && a <= 16'hFFFE);
    endfunction

    function automatic logic [7:0] reg_val(input logic [15:0] a);
        case (a)
            16'hFF04: return m_sys[15:8];
            16'hFF05: return m_tima;
            16'hFF06: return m_tma;
            16'hFF07: return {5'b11111, m_tac};
            16'hFF0F: return {3'b111, m_if};
            default:  return m_hram[a[6:0]];
        endcase
    endfunction

    task automatic model_reset();
        m_sys = 16'h0; m_tima = 8'h0; m_tma = 8'h0; m_tac = 3'b0; m_tprev = 1'b0;
        m_if = 5'h0; m_rdata = 8'h0; m_rvalid = 1'b0; m_rknown = 1'b1;
`ifdef GB_TIMA_RELOAD_DELAY_EN
        m_stage = 0;
`endif
    endtask

    task automatic model_step();
        logic [15:0] a;
        logic        hit, we, wtima, t_now, fall, tset;
        logic [7:0]  tma_new;
        logic [4:0]  set;
        a   = addr_i;
        hit = in_range(a);
        we  = wr_i && hit;
        if (rd_i && hit) begin
            m_rvalid = 1'b1;
            if (a >= 16'hFF80 && !m_ok[a[6:0]]) m_rknown = 1'b0;
            else begin m_rknown = 1'b1; m_rdata = reg_val(a); end
        end else begin
            m_rvalid = 1'b0;
        end
        t_now   = m_tac[2] && m_sys[kmap[m_tac[1:0]]];
        fall    = m_tprev && !t_now;
        m_tprev = t_now;
        tma_new = (we && a == 16'hFF06) ? wdata_i : m_tma;
        wtima   = we && a == 16'hFF05;
        tset    = 1'b0;
`ifdef GB_TIMA_RELOAD_DELAY_EN
        if (m_stage == 1) begin
            if (wtima) begin m_tima = wdata_i; m_stage = 0; end
            else begin m_tima = tma_new; tset = 1'b1; m_stage = 2; end
        end else begin
            logic ignore_w;
            ignore_w = (m_stage == 2);
            m_stage  = 0;
            if (wtima && !ignore_w) m_tima = wdata_i;
            else if (fall) begin
                if (m_tima == 8'hFF) begin m_tima = 8'h00; m_stage = 1; end
                else m_tima = m_tima + 8'd1;
            end
        end
`else
        if (wtima) m_tima = wdata_i;
        else if (fall) begin
            if (m_tima == 8'hFF) begin m_tima = tma_new; tset = 1'b1; end
            else m_tima = m_tima + 8'd1;
        end
`endif
        m_sys = (we && a == 16'hFF04) ? 16'h0000 : m_sys + 16'd4;
        m_tma = tma_new;
        if (we && a == 16'hFF07) m_tac = wdata_i[2:0];
        set  = (irq_req_i & 5'b11011) | {2'b00, tset, 2'b00};
        m_if = set | ((we && a == 16'hFF0F) ? wdata_i[4:0] : (m_if & ~irq_ack_i));
        if (we && a >= 16'hFF80) begin m_hram[a[6:0]] = wdata_i; m_ok[a[6:0]] = 1'b1; end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("rvalid", 32'(rvalid_o), 32'(m_rvalid));
            if (m_rknown) check("rdata", 32'(rdata_o), 32'(m_rdata));
            check("if_o", 32'(if_o), 32'(m_if));
            check("sel_o", 32'(sel_o), 32'(in_range(addr_i)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_bus(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
        @(negedge clk); #2;
        addr_i = a; wdata_i = d; wr_i = w; rd_i = r;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        set_bus(a, d, 1'b1, 1'b0);
        set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_read(input logic [15:0] a, output logic [7:0] d, output logic v);
        set_bus(a, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #1;
        d = rdata_o; v = rvalid_o;
        set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic       v;
        logic       found;
        addr_i = 16'h0; wdata_i = 8'h0; wr_i = 1'b0; rd_i = 1'b0;
        irq_req_i = 5'h0; irq_ack_i = 5'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rvalid", 32'(rvalid_o), 32'h0);
        check("reset_rdata", 32'(rdata_o), 32'h0);
        check("reset_if", 32'(if_o), 32'h0);
        #2 rst_n = 1'b1;

        // 1: HRAM write/read and decode edge
        do_write(16'hFF80, 8'hA5);
        do_write(16'hFFFE, 8'h3C);
        do_read(16'hFF80, d, v);
        check("t1_rd_ff80", 32'(d), 32'hA5);
        check("t1_rv_ff80", 32'(v), 32'h1);
        do_read(16'hFFFE, d, v);
        check("t1_rd_fffe", 32'(d), 32'h3C);
        set_bus(16'hFF7F, 8'h00, 1'b0, 1'b1);
        #1 check("t1_sel_ff7f", 32'(sel_o), 32'h0);
        @(posedge clk); #1;
        check("t1_rv_ff7f", 32'(rvalid_o), 32'h0);
        check("t1_hold", 32'(rdata_o), 32'h3C);
        set_bus(16'h0000, 8'h00, 1'b0, 1'b0);

        // 2: DIV after 64 clocks, then DIV write clears it
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (64) @(posedge clk);
        do_read(16'hFF04, d, v);
        check("t2_div_64", 32'(d), 32'h01);
        do_write(16'hFF04, 8'h77);
        do_read(16'hFF04, d, v);
        check("t2_div_clr", 32'(d), 32'h00);

        // 3: TIMA overflow reloads from TMA and raises IF[2]
        do_write(16'hFF0F, 8'h00);
        do_write(16'hFF07, 8'h05);
        do_write(16'hFF06, 8'hF0);
        do_write(16'hFF05, 8'hFE);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            found = if_o[2];
        end
        check("t3_irq_seen", 32'(found), 32'h1);
        check("t3_if", 32'(if_o), 32'h04);
        do_read(16'hFF05, d, v);
        check("t3_tima", 32'(d), 32'hF0);

`ifdef GB_TIMA_RELOAD_DELAY_EN
        // 4: write in the 0x00 window cancels reload and interrupt
        do_write(16'hFF0F, 8'h00);
        do_write(16'hFF05, 8'hFF);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            found = (m_stage == 1);
        end
        check("t4_window_seen", 32'(found), 32'h1);
        set_bus(16'hFF05, 8'h12, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("t4_window_rd", 32'(rdata_o), 32'h00);
        set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
        do_read(16'hFF05, d, v);
        check("t4_tima", 32'(d), 32'h12);
        check("t4_if2", 32'(if_o[2]), 32'h0);
`endif

        // 5: request beats ack; ack alone clears; IF reads with high bits set
        do_write(16'hFF07, 8'h00);
        do_write(16'hFF0F, 8'h00);
        set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
        irq_req_i = 5'h01; irq_ack_i = 5'h01;
        @(posedge clk); #1;
        check("t5_req_vs_ack", 32'(if_o), 32'h01);
        set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
        irq_req_i = 5'h00; irq_ack_i = 5'h01;
        @(posedge clk); #1;
        check("t5_ack", 32'(if_o), 32'h00);
        set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
        irq_ack_i = 5'h00;
        do_read(16'hFF0F, d, v);
        check("t5_if_read", 32'(d), 32'hE0);

        // 6: DIV write with sys bit 9 high ticks TIMA; reset mid-read
        do_write(16'hFF07, 8'h04);
        do_write(16'hFF04, 8'h00);
        do_write(16'hFF05, 8'h40);
        repeat (150) @(posedge clk);
        do_write(16'hFF04, 8'h00);
        do_read(16'hFF05, d, v);
        check("t6_div_tick", 32'(d), 32'h41);
        do_read(16'hFF07, d, v);
        check("t6_tac_read", 32'(d), 32'hFC);
        set_bus(16'hFF80, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("t6_pre_rst_rv", 32'(rvalid_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_rvalid", 32'(rvalid_o), 32'h0);
        check("t6_rst_rdata", 32'(rdata_o), 32'h00);
        set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
        @(negedge clk); #2 rst_n = 1'b1;
        do_read(16'hFF05, d, v);
        check("t6_tima_rst", 32'(d), 32'h00);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a;
            logic        w, r;
            case ($urandom_range(0, 7))
                0, 1:    a = 16'hFF04 + 16'($urandom_range(0, 3));
                2:       a = 16'hFF0F;
                3, 4, 5: a = 16'hFF80 + 16'($urandom_range(0, 127));
                6:       a = 16'hFF7F - 16'($urandom_range(0, 15));
                default: a = 16'($urandom);
            endcase
            w = ($urandom_range(0, 9) < 4);
            r = ($urandom_range(0, 1) == 1);
            if (a == 16'hFF04 && w && $urandom_range(0, 7) != 0) w = 1'b0;
            set_bus(a, 8'($urandom), w, r);
            irq_req_i = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'h00;
            irq_ack_i = ($urandom_range(0, 3) == 0) ? 5'(5'h01 << $urandom_range(0, 4)) : 5'h00;
        end
        set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
        irq_req_i = 5'h00; irq_ack_i = 5'h00;
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
